pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Multi-cycle fetch/execute sequencer for the 8-bit nRisc program counter.
//  - Drives the PC's Endereco/EscPC pair and the instruction-register write strobe.
//  - Selects the next address from: PC+1, jump, conditional branch, call or return.
//  - Each instruction takes 3 cycles: BUSCA -> DECODIFICA -> EXECUTA.
// PARAMETERS
//  ADDR_W       8      address width (PC width)
//  RESET_VEC    8'h00  Endereco value after reset
//  STACK_DEPTH  4      return-stack entries (RETURN_STACK_EN only), power of 2
// PORTS
//  Clock     in   1       system clock, posedge
//  Reset     in   1       async, active-high
//  Stall     in   1       hold current state; suppress all strobes
//  Fim       in   1       halt instruction decoded
//  Salto     in   1       unconditional jump
//  Desvio    in   1       conditional branch
//  Condicao  in   1       branch condition (from ALU flag)
//  Chamada   in   1       call (push return address, jump)
//  Retorno   in   1       return (pop address)
//  Alvo      in   ADDR_W  jump/branch/call target
//  PCAtual   in   ADDR_W  current PC output (SaidaPC)
//  Endereco  out  ADDR_W  next PC value, to PC input
//  EscPC     out  1       PC write enable
//  EscIR     out  1       instruction register write enable
//  Estado    out  2       FSM state, for debug
//  Parado    out  1       1 while halted
//  ErroPilha out  1       sticky stack over/underflow
// BEHAVIOUR
//  - States (Estado encoding): BUSCA=00, DECODIFICA=01, EXECUTA=10, PARADO=11.
//  - Transitions:
//    - BUSCA -> DECODIFICA.
//    - DECODIFICA -> PARADO if Fim, else -> EXECUTA.
//    - EXECUTA -> BUSCA.
//    - PARADO holds until Reset.
//  - Stall=1 freezes the state register and the stack. Endereco holds its value.
//  - Strobes are combinational from state:
//    - EscIR = (BUSCA & ~Stall & ~Reset)
//    - EscPC = (EXECUTA & ~Stall & ~Reset)
//  - Endereco is registered on the DECODIFICA->EXECUTA edge from inputs sampled
//    in DECODIFICA. Priority order:
//    1. Retorno        -> stack top
//    2. Chamada        -> Alvo
//    3. Salto          -> Alvo
//    4. Desvio&Condicao-> Alvo
//    5. otherwise      -> PCAtual+1
//  - PC+1 is mod 2^ADDR_W (8'hFF -> 8'h00). There is no carry out.
//  - Endereco is stable for the whole EXECUTA cycle. The PC captures it at the
//    posedge that ends EXECUTA. The new PC is visible on SaidaPC after the next
//    negedge, i.e. in time for the following BUSCA.
//  - Parado = (state==PARADO). In PARADO both strobes stay 0 and Endereco holds.
//  - Reset (async, at any point, including mid-instruction):
//    - state=BUSCA, Endereco=RESET_VEC, stack pointer=0, ErroPilha=0.
//    - EscPC=0, EscIR=0 while Reset=1.
//    - The first BUSCA occurs in the first cycle after Reset falls.
// CONFIGURATION
//  RETURN_STACK_EN defined:
//   - Adds a STACK_DEPTH-entry LIFO. Push/pop happen on the DECODIFICA->EXECUTA edge.
//   - Chamada pushes PCAtual+1.
//   - Chamada on a full stack: push is dropped, ErroPilha=1, jump to Alvo still taken.
//   - Retorno on an empty stack: ErroPilha=1, Endereco=PCAtual+1, no pop.
//   - Chamada and Retorno together: Retorno wins; no push occurs.
//  RETURN_STACK_EN undefined:
//   - No stack storage is built.
//   - Chamada behaves exactly as Salto.
//   - Retorno is ignored (falls through to lower-priority sources).
//   - ErroPilha is tied to 0.
// TESTING
//  - Reset, then 3 idle instructions with PCAtual tracking Endereco:
//    EscIR high in cycles 0,3,6; EscPC high in cycles 2,5,8;
//    Endereco = 01, 02, 03.
//  - PCAtual=8'hFF, no control inputs -> Endereco=8'h00 in EXECUTA.
//  - Desvio=1, Condicao=0, Alvo=40 -> Endereco=PC+1.
//    Desvio=1, Condicao=1 -> Endereco=40.
//    Salto=1 with Desvio=1 and Alvo=40 -> Endereco=40.
//  - Stall held for 2 cycles in EXECUTA -> EscPC=0 for those cycles,
//    Estado=10 held, Endereco unchanged; EscPC pulses once Stall falls.
//  - Fim in DECODIFICA -> Estado=11, Parado=1, no strobes for 10 cycles.
//    Reset mid-EXECUTA -> Endereco=RESET_VEC, EscPC=0 immediately.
//  - RETURN_STACK_EN:
//    - PCAtual=10, Chamada, Alvo=80 -> Endereco=80; then Retorno -> Endereco=11.
//    - 5 nested calls -> ErroPilha=1 on the 5th.
//    - Retorno on an empty stack -> ErroPilha=1, Endereco=PC+1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: BUSCA/DECODIFICA/EXECUTA sequencer for the 8-bit nRisc PC.
// Picks the next PC from return/call/jump/branch/PC+1 and drives EscPC/EscIR.
// Optional feature macro: RETURN_STACK_EN (adds a STACK_DEPTH-entry return stack).
module pc_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                STACK_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Fim,
  input  logic              Salto,
  input  logic              Desvio,
  input  logic              Condicao,
  input  logic              Chamada,
  input  logic              Retorno,
  input  logic [ADDR_W-1:0] Alvo,
  input  logic [ADDR_W-1:0] PCAtual,
  output logic [ADDR_W-1:0] Endereco,
  output logic              EscPC,
  output logic              EscIR,
  output logic [1:0]        Estado,
  output logic              Parado,
  output logic              ErroPilha
);

  typedef enum logic [1:0] {
    BUSCA      = 2'b00,
    DECODIFICA = 2'b01,
    EXECUTA    = 2'b10,
    PARADO     = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] end_nx;
  logic              load;

  // PC+1 wraps naturally at ADDR_W bits
  assign pc_inc = PCAtual + ONE;

  // Endereco is only captured when DECODIFICA actually advances to EXECUTA
  assign load = (state == DECODIFICA) && !Stall && !Fim;

  // State register; Stall is folded into next-state as a hold
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= BUSCA;
    else       state <= state_nx;
  end

  // Next-state logic; PARADO only leaves through Reset
  always_comb begin
    state_nx = state;
    if (!Stall) begin
      case (state)
        BUSCA:      state_nx = DECODIFICA;
        DECODIFICA: state_nx = Fim ? PARADO : EXECUTA;
        EXECUTA:    state_nx = BUSCA;
        default:    state_nx = PARADO;
      endcase
    end
  end

  // Strobes are combinational so Reset/Stall kill them in the same cycle
  assign EscIR  = (state == BUSCA)   && !Stall && !Reset;
  assign EscPC  = (state == EXECUTA) && !Stall && !Reset;
  assign Estado = state;
  assign Parado = (state == PARADO);

`ifdef RETURN_STACK_EN
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  top_idx;
  logic              empty, full, push, pop, err_set;

  assign empty   = (sp == '0);
  assign full    = (sp == SP_FULL);
  assign top_idx = IDX_W'(sp - SP_ONE);

  // Source select: Retorno > Chamada > Salto > taken branch > PC+1
  always_comb begin
    end_nx  = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (Retorno) begin
      if (!empty) begin
        end_nx = stack_mem[top_idx];
        pop    = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (Chamada) begin
      end_nx = Alvo;
      if (full) err_set = 1'b1;
      else      push    = 1'b1;
    end else if (Salto || (Desvio && Condicao)) begin
      end_nx = Alvo;
    end
  end

  // Stack pointer moves only on the DECODIFICA->EXECUTA edge
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)             sp <= '0;
    else if (load && push) sp <= sp + SP_ONE;
    else if (load && pop)  sp <= sp - SP_ONE;
  end

  // Stack storage needs no reset; sp alone defines validity
  always_ff @(posedge Clock) begin
    if (load && push && !Reset) stack_mem[sp[IDX_W-1:0]] <= pc_inc;
  end

  // Sticky over/underflow flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                ErroPilha <= 1'b0;
    else if (load && err_set) ErroPilha <= 1'b1;
  end
`else
  logic unused_retorno;
  assign unused_retorno = Retorno;

  // Source select without a stack: Chamada acts as Salto, Retorno ignored
  always_comb begin
    end_nx = pc_inc;
    if (Chamada || Salto || (Desvio && Condicao)) end_nx = Alvo;
  end

  assign ErroPilha = 1'b0;
`endif

  // Next-address register, held through Stall, PARADO and the rest of the instruction
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)     Endereco <= RESET_VEC;
    else if (load) Endereco <= end_nx;
  end

endmodule
